// File: rtl/hsiao_secded_decoder_pipe.sv
// Two-stage elastic Hsiao SEC-DED decoder with saturating error counters.
// Optional last-error log, built in when HSIAO_ERR_LOG_EN is defined.
module hsiao_secded_decoder_pipe #(
    parameter int DATA_W = 8,
    parameter int PAR_W  = 5,
    parameter int CNT_W  = 16,
    localparam int CODE_W = DATA_W + PAR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              single_error_corrected,
    output logic              double_error_detected,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count,
    output logic              err_log_valid,
    output logic [PAR_W-1:0]  err_log_syndrome,
    output logic              err_log_double
);

    generate
        if (!((DATA_W == 8  && PAR_W == 5) || (DATA_W == 16 && PAR_W == 6) ||
              (DATA_W == 32 && PAR_W == 7) || (DATA_W == 64 && PAR_W == 8))) begin : g_bad_param
            $error("hsiao_secded_decoder_pipe: illegal DATA_W/PAR_W pair");
        end
    endgenerate

    // Data columns: weight-3 values ascending, then weight-5 values ascending.
    function automatic logic [DATA_W-1:0][PAR_W-1:0] gen_cols();
        logic [DATA_W-1:0][PAR_W-1:0] c;
        int n;
        c = '0;
        n = 0;
        for (int w = 3; w <= 5; w += 2) begin
            for (int v = 0; v < (1 << PAR_W); v++) begin
                if ($countones(v[PAR_W-1:0]) == w && n < DATA_W) begin
                    c[n] = v[PAR_W-1:0];
                    n++;
                end
            end
        end
        return c;
    endfunction

    localparam logic [DATA_W-1:0][PAR_W-1:0] H_COLS = gen_cols();

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic [PAR_W-1:0]  s1_syn_q,   s1_syn_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              sec_q,      sec_d;
    logic              ded_q,      ded_d;
    logic [CNT_W-1:0]  sec_cnt_q,  sec_cnt_d;
    logic [CNT_W-1:0]  ded_cnt_q,  ded_cnt_d;

    logic              s2_take;
    logic              s1_move;
    logic              in_fire;
    logic              out_fire;
    logic [PAR_W-1:0]  syn;
    logic [DATA_W-1:0] fix_data;
    logic              fix_sec;
    logic              fix_ded;
    logic              matched;

    assign s2_take  = !s2_valid_q || out_ready;
    assign s1_move  = s1_valid_q && s2_take;
    assign in_ready = !s1_valid_q || s1_move;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        syn = in_code[PAR_W-1:0];
        for (int j = 0; j < PAR_W; j++) begin
            for (int i = 0; i < DATA_W; i++) begin
                syn[j] = syn[j] ^ (H_COLS[i][j] & in_code[PAR_W+i]);
            end
        end
    end

    // A check-bit column hit still counts as corrected; the data needs no flip.
    always_comb begin
        fix_data = s1_data_q;
        fix_sec  = 1'b0;
        fix_ded  = 1'b0;
        matched  = 1'b0;
        if (s1_syn_q != '0) begin
            if (^s1_syn_q) begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (s1_syn_q == H_COLS[i]) begin
                        fix_data[i] = ~fix_data[i];
                        matched     = 1'b1;
                    end
                end
                for (int j = 0; j < PAR_W; j++) begin
                    if (s1_syn_q == (PAR_W'(1) << j)) matched = 1'b1;
                end
                fix_sec = matched;
                fix_ded = !matched;
            end else begin
                fix_ded = 1'b1;
            end
        end
    end

    // Only the data field is carried forward; the check bits are consumed by the syndrome.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_code[CODE_W-1:PAR_W];
            s1_syn_d   = syn;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        sec_d      = sec_q;
        ded_d      = ded_q;
        if (s1_move) begin
            s2_valid_d = 1'b1;
            out_data_d = fix_data;
            sec_d      = fix_sec;
            ded_d      = fix_ded;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (cnt_clr) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (out_fire) begin
            if (sec_q && sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + CNT_W'(1);
            if (ded_q && ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            sec_q      <= 1'b0;
            ded_q      <= 1'b0;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_syn_q   <= s1_syn_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
            sec_q      <= sec_d;
            ded_q      <= ded_d;
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
        end
    end

    assign out_valid              = s2_valid_q;
    assign out_data               = out_data_q;
    assign single_error_corrected = sec_q;
    assign double_error_detected  = ded_q;
    assign sec_count              = sec_cnt_q;
    assign ded_count              = ded_cnt_q;

`ifdef HSIAO_ERR_LOG_EN
    logic [PAR_W-1:0] s2_syn_q,     s2_syn_d;
    logic             log_valid_q,  log_valid_d;
    logic [PAR_W-1:0] log_syn_q,    log_syn_d;
    logic             log_double_q, log_double_d;

    always_comb begin
        s2_syn_d     = s1_move ? s1_syn_q : s2_syn_q;
        log_valid_d  = log_valid_q;
        log_syn_d    = log_syn_q;
        log_double_d = log_double_q;
        if (cnt_clr) begin
            log_valid_d  = 1'b0;
            log_syn_d    = '0;
            log_double_d = 1'b0;
        end else if (out_fire && (sec_q || ded_q)) begin
            log_valid_d  = 1'b1;
            log_syn_d    = s2_syn_q;
            log_double_d = ded_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_syn_q     <= '0;
            log_valid_q  <= 1'b0;
            log_syn_q    <= '0;
            log_double_q <= 1'b0;
        end else begin
            s2_syn_q     <= s2_syn_d;
            log_valid_q  <= log_valid_d;
            log_syn_q    <= log_syn_d;
            log_double_q <= log_double_d;
        end
    end

    assign err_log_valid    = log_valid_q;
    assign err_log_syndrome = log_syn_q;
    assign err_log_double   = log_double_q;
`else
    assign err_log_valid    = 1'b0;
    assign err_log_syndrome = '0;
    assign err_log_double   = 1'b0;
`endif

endmodule

// File: tb/tb_hsiao_secded_decoder_pipe.sv
// Directed + scoreboard bench for hsiao_secded_decoder_pipe at DATA_W=8, PAR_W=5.
module tb_hsiao_secded_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [12:0] in_code;
    logic [7:0]  out_data;
    logic        sec, ded, log_valid, log_double;
    logic [15:0] sec_count, ded_count;
    logic [4:0]  log_syn;

    hsiao_secded_decoder_pipe #(.DATA_W(8), .PAR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .single_error_corrected(sec), .double_error_detected(ded), .cnt_clr(cnt_clr),
        .sec_count(sec_count), .ded_count(ded_count), .err_log_valid(log_valid),
        .err_log_syndrome(log_syn), .err_log_double(log_double)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] d; logic s; logic dd; } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_sec = 16'h0;
    logic [15:0] exp_ded = 16'h0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent encoder: weight-3 columns of 5 bits, ascending.
    function automatic logic [4:0] enc(input logic [7:0] d);
        logic [7:0][4:0] cols;
        logic [4:0] p;
        cols = {5'd25, 5'd22, 5'd21, 5'd19, 5'd14, 5'd13, 5'd11, 5'd7};
        p = '0;
        for (int j = 0; j < 5; j++)
            for (int i = 0; i < 8; i++)
                p[j] = p[j] ^ (d[i] & cols[i][j]);
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input exp_t e);
        q.push_back(e);
        if (e.s && exp_sec != 16'hFFFF) exp_sec++;
        if (e.dd && exp_ded != 16'hFFFF) exp_ded++;
    endtask

    task automatic send(input logic [12:0] code, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_code  = code;
        #1;
        while (!in_ready && n < 50) begin step(); n++; end
        chk("send_accept", in_ready, 1'b1);
        push_exp(e);
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin step(); n++; end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic gen_word(output logic [12:0] code, output exp_t e);
        logic [7:0] d;
        int k, b1, b2;
        d    = 8'($urandom);
        code = {d, enc(d)};
        k    = $urandom_range(0, 2);
        b1   = $urandom_range(0, 12);
        b2   = (b1 + $urandom_range(1, 12)) % 13;
        e.d = d; e.s = 1'b0; e.dd = 1'b0;
        if (k == 1) begin
            code[b1] = ~code[b1];
            e.s = 1'b1;
        end else if (k == 2) begin
            code[b1] = ~code[b1];
            code[b2] = ~code[b2];
            e.d  = code[12:5];
            e.dd = 1'b1;
        end
    endtask

    // Output monitor: scoreboard pop on each transfer, stability check while stalled.
    exp_t       mon_e;
    logic       stalled = 1'b0;
    logic [9:0] stall_val;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) chk("stall_stable", {out_data, sec, ded}, stall_val);
            if (out_valid && out_ready) begin
                chk("sb_has_entry", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("out_data", out_data, mon_e.d);
                    chk("out_sec", sec, mon_e.s);
                    chk("out_ded", ded, mon_e.dd);
                end
            end
            stalled   = out_valid && !out_ready;
            stall_val = {out_data, sec, ded};
        end
    end

    initial begin
        logic [12:0] code;
        exp_t e;
        int k, n;
        logic [12:0] w[4];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; in_code = '0;
        step(); step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_fields", {out_data, sec, ded}, 10'h0);
        chk("rst_counts", {sec_count, ded_count}, 32'h0);
        chk("rst_log", {log_valid, log_syn, log_double}, 7'h0);
        rst = 1'b0;
        step();

        // Clean word and its latency.
        send(13'h1FE6, '{8'hFF, 1'b0, 1'b0});
        in_valid = 1'b0;
        chk("lat_edge1_invalid", out_valid, 1'b0);
        step();
        chk("lat_edge2_valid", out_valid, 1'b1);
        chk("lat_data", {out_data, sec, ded}, {8'hFF, 2'b00});
        drain();

        // Data bit 0 flipped.
        send(13'h1FC6, '{8'hFF, 1'b1, 1'b0});
        drain();
        chk("sec_count_1", sec_count, exp_sec);
`ifdef HSIAO_ERR_LOG_EN
        chk("log_sec", {log_valid, log_syn, log_double}, {1'b1, 5'b00111, 1'b0});
`else
        chk("log_tied0_a", {log_valid, log_syn, log_double}, 7'h0);
`endif

        // Check bits 0 and 1 flipped.
        send(13'h1FE5, '{8'hFF, 1'b0, 1'b1});
        drain();
        chk("ded_count_1", ded_count, exp_ded);
`ifdef HSIAO_ERR_LOG_EN
        chk("log_ded", {log_valid, log_syn, log_double}, {1'b1, 5'b00011, 1'b1});
`else
        chk("log_tied0_b", {log_valid, log_syn, log_double}, 7'h0);
`endif

        // Random traffic with random backpressure and idle cycles.
        for (int c = 0; c < 60; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            gen_word(code, e);
            in_code = code;
            #1;
            if (in_valid && in_ready) push_exp(e);
            step();
        end
        drain();
        chk("rand_sec_count", sec_count, exp_sec);
        chk("rand_ded_count", ded_count, exp_ded);

        // Four back-to-back words into a stalled output.
        for (int i = 0; i < 4; i++) w[i] = {8'(8'h30 + i), enc(8'(8'h30 + i))};
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_code  = w[k];
            #1;
            if (in_ready) begin push_exp('{w[k][12:5], 1'b0, 1'b0}); k++; end
            step();
        end
        chk("stall_accepted", k, 2);
        chk("stall_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        n = 0;
        while (k < 4 && n < 20) begin
            in_code = w[k];
            #1;
            if (in_ready) begin push_exp('{w[k][12:5], 1'b0, 1'b0}); k++; end
            step();
            n++;
        end
        chk("stall_all_sent", k, 4);
        drain();

        // Counter clear, then saturation.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_sec = '0; exp_ded = '0;
        chk("clr_counts", {sec_count, ded_count}, 32'h0);
        chk("clr_log", log_valid, 1'b0);
        in_valid = 1'b1; in_code = 13'h1FC6; out_ready = 1'b1;
        n = 0; k = 0;
        #1;
        while (k < 65535 && n < 70000) begin
            if (in_ready) begin push_exp('{8'hFF, 1'b1, 1'b0}); k++; end
            step();
            n++;
        end
        drain();
        chk("sat_reached", sec_count, exp_sec);
        chk("sat_value", sec_count, 16'hFFFF);
        send(13'h1FC6, '{8'hFF, 1'b1, 1'b0});
        drain();
        chk("sat_hold", sec_count, exp_sec);
        out_ready = 1'b0;
        send(13'h1FC6, '{8'hFF, 1'b1, 1'b0});
        in_valid = 1'b0;
        step();
        chk("clr_vs_inc_parked", out_valid, 1'b1);
        out_ready = 1'b1; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_sec = '0;
        chk("clr_wins", sec_count, exp_sec);

        // Reset with two words in flight.
        send(13'h1FC6, '{8'hFF, 1'b1, 1'b0});
        drain();
        chk("pre_rst_sec", sec_count, exp_sec);
        out_ready = 1'b0;
        send(13'h1FC6, '{8'hFF, 1'b1, 1'b0});
        send(13'h1FE5, '{8'hFF, 1'b0, 1'b1});
        in_valid = 1'b0;
        rst = 1'b1; out_ready = 1'b1; cnt_clr = 1'b1;
        q.delete();
        exp_sec = '0; exp_ded = '0;
        step();
        chk("rst2_out_valid", out_valid, 1'b0);
        chk("rst2_counts", {sec_count, ded_count}, 32'h0);
        chk("rst2_in_ready", in_ready, 1'b1);
        rst = 1'b0; cnt_clr = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk("rst2_no_output", out_valid, 1'b0);
        chk("rst2_log", {log_valid, log_syn, log_double}, 7'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
